// File: rtl/codec_cmd_sequencer.sv
// codec_cmd_sequencer: owns the codec I2C controller command port. Walks the
// SSM2603 init table after reset or on request, then serves software commands,
// with missed-ack / timeout detection, bounded retries and per-command status.
module codec_cmd_sequencer #(
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned XFER_TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic       sw_req,
  input  logic       sw_rnw,
  input  logic [6:0] sw_addr,
  input  logic [8:0] sw_wdata,
  output logic       sw_ack,
  output logic [8:0] sw_rdata,
  output logic [1:0] sw_err,
  output logic       init_done,
  output logic       init_error,
  output logic       cmd_rd_en,
  output logic       cmd_wr_en,
  output logic [7:0] cmd_addr,
  output logic [8:0] cmd_wdata,
  input  logic       ctrl_busy,
  input  logic       ctrl_rd_valid,
  input  logic [8:0] ctrl_rd_data,
  input  logic       ctrl_missed_ack
);

  localparam int unsigned TBL_LEN = 12;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TMR_W   = 16;
  localparam int unsigned RTY_W   = 2;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISSACK = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               init_pend;
  logic               init_lat;
  logic               cur_sw;
  logic               cur_rd;
  logic [TMR_W-1:0]   timer;
  logic [RTY_W-1:0]   retry_cnt;
  logic               missed;
  logic [8:0]         rdata_cap;

  logic               init_go_c;
  logic [IDX_W-1:0]   entry_idx_c;
  logic [15:0]        entry_c;
  logic               fail_c;
  logic               ok_c;
  logic               retry_c;
  logic               finish_c;
  logic [1:0]         code_c;

  // Init table entry as {addr[6:0], data[8:0]}
  function automatic logic [15:0] tbl_entry(input logic [IDX_W-1:0] i);
    logic [15:0] e;
    case (i)
      4'd0:    e = {7'h0F, 9'h000};
      4'd1:    e = {7'h06, 9'h030};
      4'd2:    e = {7'h00, 9'h017};
      4'd3:    e = {7'h01, 9'h017};
      4'd4:    e = {7'h02, 9'h079};
      4'd5:    e = {7'h03, 9'h079};
      4'd6:    e = {7'h04, 9'h010};
      4'd7:    e = {7'h05, 9'h000};
      4'd8:    e = {7'h07, 9'h00A};
      4'd9:    e = {7'h08, 9'h000};
      4'd10:   e = {7'h09, 9'h001};
      4'd11:   e = {7'h06, 9'h020};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  // Outcome of the current attempt: fail/succeed, and whether to retry or finish
  always_comb begin
    fail_c      = 1'b0;
    ok_c        = 1'b0;
    code_c      = ERR_OK;
    init_go_c   = init_start || init_lat;
    entry_idx_c = init_go_c ? IDX_W'(0) : idx;
    entry_c     = tbl_entry(entry_idx_c);
    case (state)
      S_WAIT_START: begin
        if (!ctrl_busy && timer == '0) begin
          fail_c = 1'b1;
          code_c = ERR_TIMEOUT;
        end
      end
      S_WAIT_DONE: begin
        // completion (busy low) beats an expiring timer
        if (ctrl_busy && timer == '0) begin
          fail_c = 1'b1;
          code_c = ERR_TIMEOUT;
        end
      end
      S_COMPLETE: begin
        if (missed) begin
          fail_c = 1'b1;
          code_c = ERR_MISSACK;
        end else begin
          ok_c = 1'b1;
        end
      end
      default: ;
    endcase
    retry_c  = fail_c && (retry_cnt < RTY_W'(MAX_RETRY));
    finish_c = ok_c || (fail_c && !retry_c);
  end

  // Command sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      init_pend  <= 1'b1;
      init_lat   <= 1'b0;
      cur_sw     <= 1'b0;
      cur_rd     <= 1'b0;
      timer      <= '0;
      retry_cnt  <= '0;
      missed     <= 1'b0;
      rdata_cap  <= '0;
      sw_ack     <= 1'b0;
      sw_rdata   <= '0;
      sw_err     <= '0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      cmd_rd_en  <= 1'b0;
      cmd_wr_en  <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else begin
      cmd_rd_en <= 1'b0;
      cmd_wr_en <= 1'b0;
      sw_ack    <= 1'b0;
      // a rerun request outside IDLE waits here until the next IDLE
      if (init_start) init_lat <= 1'b1;

      case (state)
        S_IDLE: begin
          if (init_go_c || init_pend) begin
            if (init_go_c) begin
              init_lat   <= 1'b0;
              init_pend  <= 1'b1;
              init_done  <= 1'b0;
              init_error <= 1'b0;
              idx        <= '0;
            end
            cur_sw    <= 1'b0;
            cur_rd    <= 1'b0;
            cmd_wr_en <= 1'b1;
            cmd_addr  <= {1'b0, entry_c[15:9]};
            cmd_wdata <= entry_c[8:0];
            state     <= S_ISSUE;
          end else if (sw_req && !sw_ack) begin
            // the ack cycle still sees the old request high; skip it
            cur_sw    <= 1'b1;
            cur_rd    <= sw_rnw;
            cmd_rd_en <= sw_rnw;
            cmd_wr_en <= ~sw_rnw;
            cmd_addr  <= {1'b0, sw_addr};
            cmd_wdata <= sw_wdata;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          missed    <= 1'b0;
          rdata_cap <= '0;
          timer     <= TMR_W'(START_TIMEOUT);
          state     <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (ctrl_busy) begin
            timer  <= TMR_W'(XFER_TIMEOUT);
            missed <= missed | ctrl_missed_ack;
            if (ctrl_rd_valid) rdata_cap <= ctrl_rd_data;
            state  <= S_WAIT_DONE;
          end else if (timer != '0) begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (ctrl_busy) begin
            missed <= missed | ctrl_missed_ack;
            if (ctrl_rd_valid) rdata_cap <= ctrl_rd_data;
            if (timer != '0) timer <= timer - TMR_W'(1);
          end else begin
            state <= S_COMPLETE;
          end
        end
        S_COMPLETE: ;
        default: state <= S_IDLE;
      endcase

      if (retry_c) begin
        retry_cnt <= retry_cnt + RTY_W'(1);
        cmd_rd_en <= cur_rd;
        cmd_wr_en <= ~cur_rd;
        state     <= S_ISSUE;
      end else if (finish_c) begin
        retry_cnt <= '0;
        state     <= S_IDLE;
        if (cur_sw) begin
          sw_ack   <= 1'b1;
          sw_err   <= code_c;
          sw_rdata <= rdata_cap;
        end else if (fail_c) begin
          init_error <= 1'b1;
          init_pend  <= 1'b0;
        end else if (idx == IDX_W'(TBL_LEN - 1)) begin
          init_done <= 1'b1;
          init_pend <= 1'b0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_cmd_sequencer.sv
// Directed bench for codec_cmd_sequencer with a behavioural I2C controller model.
module tb_codec_cmd_sequencer;

  localparam int START_TIMEOUT = 16;
  localparam int M_DELAY       = 3;
  localparam int M_LEN         = 100;
  localparam int LOG_N         = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_start = 1'b0;
  logic       sw_req = 1'b0;
  logic       sw_rnw = 1'b0;
  logic [6:0] sw_addr = '0;
  logic [8:0] sw_wdata = '0;
  logic       sw_ack;
  logic [8:0] sw_rdata;
  logic [1:0] sw_err;
  logic       init_done;
  logic       init_error;
  logic       cmd_rd_en;
  logic       cmd_wr_en;
  logic [7:0] cmd_addr;
  logic [8:0] cmd_wdata;
  logic       ctrl_busy = 1'b0;
  logic       ctrl_rd_valid = 1'b0;
  logic [8:0] ctrl_rd_data = '0;
  logic       ctrl_missed_ack = 1'b0;

  codec_cmd_sequencer dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .sw_req(sw_req), .sw_rnw(sw_rnw), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .sw_ack(sw_ack), .sw_rdata(sw_rdata), .sw_err(sw_err),
    .init_done(init_done), .init_error(init_error),
    .cmd_rd_en(cmd_rd_en), .cmd_wr_en(cmd_wr_en),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .ctrl_busy(ctrl_busy), .ctrl_rd_valid(ctrl_rd_valid),
    .ctrl_rd_data(ctrl_rd_data), .ctrl_missed_ack(ctrl_missed_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] tbl_addr [12] = '{7'h0F, 7'h06, 7'h00, 7'h01, 7'h02, 7'h03,
                                7'h04, 7'h05, 7'h07, 7'h08, 7'h09, 7'h06};
  logic [8:0] tbl_data [12] = '{9'h000, 9'h030, 9'h017, 9'h017, 9'h079, 9'h079,
                                9'h010, 9'h000, 9'h00A, 9'h000, 9'h001, 9'h020};

  function automatic logic [17:0] tbl_exp(input int e);
    return {1'b0, 1'b0, tbl_addr[e], tbl_data[e]};
  endfunction

  // controller model configuration and pulse log
  bit         cfg_never_busy = 1'b0;
  int         cfg_miss_n = 0;
  bit         cfg_miss_addr_en = 1'b0;
  logic [6:0] cfg_miss_addr = '0;
  logic [8:0] cfg_rd_val = '0;
  int         base = 0;
  int         n_pulse = 0;
  logic [17:0] log_cmd [LOG_N];
  int          log_cyc [LOG_N];
  int          m_phase = 0;
  int          m_cnt = 0;
  bit          m_miss = 1'b0;
  bit          m_rd = 1'b0;

  // controller model: busy a few cycles after each pulse, optional missed ack / read data
  always @(negedge clk) begin
    ctrl_rd_valid = 1'b0;
    if (reset) begin
      m_phase = 0;
      ctrl_busy = 1'b0;
      ctrl_missed_ack = 1'b0;
    end else if (cmd_wr_en || cmd_rd_en) begin
      if (n_pulse < LOG_N) begin
        log_cmd[n_pulse] = {cmd_rd_en, cmd_addr, cmd_wdata};
        log_cyc[n_pulse] = cyc;
      end
      m_miss = ((n_pulse - base) < cfg_miss_n) ||
               (cfg_miss_addr_en && cmd_addr == {1'b0, cfg_miss_addr});
      m_rd = cmd_rd_en;
      n_pulse++;
      if (!cfg_never_busy) begin
        m_phase = 1;
        m_cnt = M_DELAY;
      end
    end else if (m_phase == 1) begin
      if (m_cnt <= 1) begin
        ctrl_busy = 1'b1;
        ctrl_missed_ack = m_miss;
        m_phase = 2;
        m_cnt = M_LEN;
      end else begin
        m_cnt--;
      end
    end else if (m_phase == 2) begin
      if (m_cnt == M_LEN / 2 && m_rd && !m_miss) begin
        ctrl_rd_valid = 1'b1;
        ctrl_rd_data = cfg_rd_val;
      end
      if (m_cnt <= 1) begin
        ctrl_busy = 1'b0;
        ctrl_missed_ack = 1'b0;
        m_phase = 0;
      end else begin
        m_cnt--;
      end
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " sw_ack"},     32'(sw_ack), 32'd0);
    check({tag, " sw_rdata"},   32'(sw_rdata), 32'd0);
    check({tag, " sw_err"},     32'(sw_err), 32'd0);
    check({tag, " init_done"},  32'(init_done), 32'd0);
    check({tag, " init_error"}, 32'(init_error), 32'd0);
    check({tag, " cmd_rd_en"},  32'(cmd_rd_en), 32'd0);
    check({tag, " cmd_wr_en"},  32'(cmd_wr_en), 32'd0);
    check({tag, " cmd_addr"},   32'(cmd_addr), 32'd0);
    check({tag, " cmd_wdata"},  32'(cmd_wdata), 32'd0);
  endtask

  task automatic wait_init(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (init_done || init_error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pulses(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (n_pulse - base >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok, output logic [1:0] err,
                          output logic [8:0] rd, output logic done);
    ok = 1'b0;
    err = '0;
    rd = '0;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sw_ack) begin
        ok = 1'b1;
        err = sw_err;
        rd = sw_rdata;
        done = init_done;
        break;
      end
    end
    sw_req = 1'b0;
  endtask

  task automatic check_table(input string tag, input int first, input int entry0, input int count);
    for (int k = 0; k < count; k++)
      check($sformatf("%s pulse %0d", tag, k), 32'(log_cmd[first + k]), 32'(tbl_exp(entry0 + k)));
  endtask

  typedef struct {
    logic       rnw;
    logic [6:0] addr;
    logic [8:0] wdata;
    bit         never_busy;
    int         miss_n;
    logic [8:0] rd_val;
    logic [1:0] exp_err;
    logic [8:0] exp_rdata;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit         ok;
    logic [1:0] err;
    logic [8:0] rd;
    logic       done;
    int         req_cyc;
    int         cnt;

    vecs[0] = '{1'b0, 7'h04, 9'h055, 1'b0, 0, 9'h000, 2'b00, 9'h000, 1};
    vecs[1] = '{1'b1, 7'h07, 9'h000, 1'b0, 0, 9'h00A, 2'b00, 9'h00A, 1};
    vecs[2] = '{1'b0, 7'h05, 9'h1FF, 1'b0, 1, 9'h000, 2'b00, 9'h000, 2};
    vecs[3] = '{1'b1, 7'h02, 9'h000, 1'b0, 3, 9'h123, 2'b01, 9'h000, 3};
    vecs[4] = '{1'b0, 7'h09, 9'h001, 1'b1, 0, 9'h000, 2'b10, 9'h000, 3};
    vecs[5] = '{1'b1, 7'h7F, 9'h000, 1'b0, 2, 9'h1A5, 2'b00, 9'h1A5, 3};

    // reset state and table start
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    base = n_pulse;
    @(negedge clk);
    check("first issue wr_en", 32'(cmd_wr_en), 32'd1);
    check("first issue addr", 32'(cmd_addr), 32'h0F);

    // clean init
    wait_init(3000, ok);
    check("clean init finished", 32'(ok), 32'd1);
    check("clean init_done", 32'(init_done), 32'd1);
    check("clean init_error", 32'(init_error), 32'd0);
    check("clean pulse count", 32'(n_pulse - base), 32'd12);
    check_table("clean", base, 0, 12);

    // software command vectors
    for (int i = 0; i < 6; i++) begin
      cfg_never_busy = vecs[i].never_busy;
      cfg_miss_n = vecs[i].miss_n;
      cfg_rd_val = vecs[i].rd_val;
      base = n_pulse;
      sw_rnw = vecs[i].rnw;
      sw_addr = vecs[i].addr;
      sw_wdata = vecs[i].wdata;
      sw_req = 1'b1;
      req_cyc = cyc;
      wait_ack(1000, ok, err, rd, done);
      repeat (5) @(negedge clk);
      cnt = n_pulse - base;
      check($sformatf("v%0d ack", i), 32'(ok), 32'd1);
      check($sformatf("v%0d sw_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d sw_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      check($sformatf("v%0d pulses", i), 32'(cnt), 32'(vecs[i].exp_pulses));
      check($sformatf("v%0d first cmd", i), 32'(log_cmd[base]),
            32'({vecs[i].rnw, 1'b0, vecs[i].addr, vecs[i].wdata}));
      check($sformatf("v%0d last cmd", i), 32'(log_cmd[base + vecs[i].exp_pulses - 1]),
            32'({vecs[i].rnw, 1'b0, vecs[i].addr, vecs[i].wdata}));
      check($sformatf("v%0d latency", i), 32'(log_cyc[base] - req_cyc), 32'd1);
      if (vecs[i].never_busy)
        for (int k = 1; k < cnt && k < vecs[i].exp_pulses; k++)
          check($sformatf("v%0d gap %0d", i, k),
                32'(log_cyc[base + k] - log_cyc[base + k - 1] >= START_TIMEOUT), 32'd1);
    end
    cfg_never_busy = 1'b0;
    cfg_miss_n = 0;

    // reset during a transfer
    cfg_rd_val = 9'h00A;
    base = n_pulse;
    sw_rnw = 1'b1;
    sw_addr = 7'h07;
    sw_wdata = '0;
    sw_req = 1'b1;
    wait_pulses(1, 100, ok);
    check("midreset pulse seen", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    sw_req = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    base = n_pulse;
    @(negedge clk);
    check("rerun issue wr_en", 32'(cmd_wr_en), 32'd1);
    check("rerun issue addr", 32'(cmd_addr), 32'h0F);
    wait_init(3000, ok);
    check("rerun finished", 32'(ok), 32'd1);
    check("rerun init_done", 32'(init_done), 32'd1);
    check("rerun pulse count", 32'(n_pulse - base), 32'd12);
    check_table("rerun", base, 0, 12);

    // missed ack on entry 2 for every attempt
    cfg_miss_addr_en = 1'b1;
    cfg_miss_addr = 7'h00;
    base = n_pulse;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    check("init_start clears done", 32'(init_done), 32'd0);
    check("init_start issue addr", 32'(cmd_addr), 32'h0F);
    wait_init(3000, ok);
    check("err init finished", 32'(ok), 32'd1);
    check("err init_error", 32'(init_error), 32'd1);
    check("err init_done", 32'(init_done), 32'd0);
    check_table("err", base, 0, 2);
    for (int k = 0; k < 3; k++)
      check($sformatf("err retry %0d", k), 32'(log_cmd[base + 2 + k]), 32'(tbl_exp(2)));
    repeat (300) @(negedge clk);
    check("err pulse count", 32'(n_pulse - base), 32'd5);
    cfg_miss_addr_en = 1'b0;

    // init and software together, then a rerun latched mid-command
    base = n_pulse;
    init_start = 1'b1;
    sw_rnw = 1'b0;
    sw_addr = 7'h03;
    sw_wdata = 9'h0AA;
    sw_req = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    check("arb init wins wr_en", 32'(cmd_wr_en), 32'd1);
    check("arb init wins addr", 32'(cmd_addr), 32'h0F);
    wait_pulses(5, 2000, ok);
    check("arb five pulses", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    wait_ack(5000, ok, err, rd, done);
    repeat (5) @(negedge clk);
    check("arb ack", 32'(ok), 32'd1);
    check("arb sw_err", 32'(err), 32'd0);
    check("arb init_done at ack", 32'(done), 32'd1);
    check("arb init_error", 32'(init_error), 32'd0);
    check("arb pulse count", 32'(n_pulse - base), 32'd18);
    check_table("arb first", base, 0, 5);
    check_table("arb rerun", base + 5, 0, 12);
    check("arb sw cmd", 32'(log_cmd[base + 17]), 32'({1'b0, 8'h03, 9'h0AA}));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/codec_cmd_sequencer.md
# codec_cmd_sequencer

Sits between the register unit and the codec I2C `controller_unit` in the AXI clock domain and owns the controller's single read/write command port. After reset it walks a fixed SSM2603 initialisation table, then arbitrates that port between a rerun of the table and software commands. It also detects I2C missed-ack and hung transactions, retries failed commands and reports per-command status. Fabric-side init state and software completion come from this block instead of being inferred from the controller's busy flag.

## Interface
- `MAX_RETRY`, 2: re-issues allowed after a missed ack or timeout (3 attempts total).
- `START_TIMEOUT`, 16: cycles allowed from command pulse to `ctrl_busy` rising.
- `XFER_TIMEOUT`, 65535: cycles allowed for `ctrl_busy` high, i.e. the length of one transfer.

Ports:
- `clk` in 1: AXI clock; sole clock of the block.
- `reset` in 1: **synchronous, active-high** reset.
- `init_start` in 1: one-cycle pulse that reruns the init table.
- `sw_req` in 1: software command request; level, held until `sw_ack`.
- `sw_rnw` in 1: 1 = read, 0 = write.
- `sw_addr` in 7: codec register address.
- `sw_wdata` in 9: write data.
- `sw_ack` out 1: one-cycle pulse marking the end of a software command.
- `sw_rdata` out 9: read data; valid from `sw_ack` until the next `sw_ack`.
- `sw_err` out 2: status, valid with `sw_ack`: 00 ok, 01 missed ack, 10 timeout.
- `init_done` out 1: high when the table completed with no failed entry.
- `init_error` out 1: high when any table entry exhausted its retries.
- `cmd_rd_en` out 1: one-cycle read pulse to the controller.
- `cmd_wr_en` out 1: one-cycle write pulse to the controller.
- `cmd_addr` out 8: command address, {1'b0, addr}.
- `cmd_wdata` out 9: command write data.
- `ctrl_busy` in 1: controller busy.
- `ctrl_rd_valid` in 1: controller read data valid.
- `ctrl_rd_data` in 9: controller read data.
- `ctrl_missed_ack` in 1: missed-ack flag from the controller, sampled while it is busy.

## Operation
- **Init table**, 12 entries of {addr, data}, issued in this order:
  - 0x0F/0x000
  - 0x06/0x030
  - 0x00/0x017
  - 0x01/0x017
  - 0x02/0x079
  - 0x03/0x079
  - 0x04/0x010
  - 0x05/0x000
  - 0x07/0x00A
  - 0x08/0x000
  - 0x09/0x001
  - 0x06/0x020
- **States:** IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE.
- **IDLE:**
  - Init pending: load table entry `idx` and go to ISSUE.
  - Otherwise, if `sw_req` is high: latch `sw_rnw`, `sw_addr`, `sw_wdata` and go to ISSUE.
  - Init always has priority over software.
- **ISSUE:**
  - One cycle. Pulses `cmd_wr_en`, or `cmd_rd_en` for a software read.
  - Clears the missed-ack and read-data capture; loads the timer with `START_TIMEOUT`.
  - Goes to WAIT_START.
- **WAIT_START:**
  - `ctrl_busy` = 1: reload the timer with `XFER_TIMEOUT` and go to WAIT_DONE.
  - Timer reaches 0: fail with code 10.
- **WAIT_DONE:**
  - While busy: sticky-capture `ctrl_missed_ack`; capture `ctrl_rd_data` on `ctrl_rd_valid`.
  - `ctrl_busy` = 0: go to COMPLETE.
  - Timer reaches 0: fail with code 10.
- **COMPLETE:**
  - Missed ack captured: fail with code 01.
  - Otherwise: success.
- **Fail handling:**
  - If `retry_cnt < MAX_RETRY`: increment it and return to ISSUE with the same command.
  - Else: finish with the error code.
- **Finish:**
  - `retry_cnt` is cleared.
  - Software command: `sw_ack` pulses with `sw_err` and `sw_rdata`; the next state is IDLE.
  - Init entry that failed: set `init_error`, abandon the table, clear pending.
  - Init entry that succeeded: increment `idx`. After entry 11, set `init_done` and clear pending.
- **Init pending:**
  - Set by reset release and by `init_start`.
  - `init_start` clears `init_done`, `init_error` and `idx` when it is accepted.
  - `init_start` during any non-IDLE state is latched and acted on at the next IDLE. A command in flight is never aborted.
- **Blocking software:** while init is pending or running, `sw_req` waits with no ack; it is never dropped.
- **Holding `sw_req`:**
  - `sw_req` must drop the cycle after `sw_ack`.
  - A request still high in IDLE is treated as a new command.

## Timing
- **Reset values:** all outputs 0, state IDLE, `idx` 0, init pending = 1. A reset mid-transaction drops any command pulse in the same cycle.
- **Table start:** the first ISSUE is the second cycle after `reset` deasserts.
- **Software latency:** `sw_req` sampled in IDLE → `cmd_*_en` pulse next cycle (ISSUE).
- **Completion:** `ctrl_busy` falling edge seen in WAIT_DONE → COMPLETE next cycle → `sw_ack` the following cycle. A retry re-enters ISSUE in that same cycle.
- **Retry gap:** at least 2 cycles between successive command pulses.
- **Same-cycle events:**
  - `init_start` and `sw_req` in the same IDLE cycle: init wins.
  - `ctrl_busy` falling in the cycle the timer expires: completion wins, no timeout.
- **Output stability:** `cmd_addr` and `cmd_wdata` hold from ISSUE until the next ISSUE.
- **Arithmetic:** the timer is 16 bits and saturates at 0; `retry_cnt` is 2 bits.

## Test plan
- **Clean init:** controller model returns busy 3 cycles after each pulse, held 100 cycles, acks good → exactly 12 `cmd_wr_en` pulses in table order; `init_done` = 1, `init_error` = 0.
- **Init retry then error:** missed ack on entry 2 (0x00/0x017) for all attempts → 3 pulses at 0x00, then `init_error` = 1, `init_done` = 0, no further pulses.
- **Software read:** after init, read of addr 0x07 with model returning 0x00A → `cmd_rd_en`, `cmd_addr` = 0x07, `sw_ack` with `sw_rdata` = 0x00A, `sw_err` = 00.
- **Start timeout:** controller never raises busy → 3 pulses spaced ≥ `START_TIMEOUT`; `sw_ack` with `sw_err` = 10.
- **Arbitration and latching:** `sw_req` asserted during init and `init_start` pulsed mid-command → current command completes; the table reruns from entry 0; the software command is then served once.
- **Reset mid-transfer:** `reset` asserted in WAIT_DONE → outputs 0 on the next cycle; init restarts at entry 0 after release.
